// File: rtl/ma_stage_pkg.sv
// rtl/ma_stage_pkg.sv - widths, MA control field layout and FSM states shared by the ma_stage slice
package ma_stage_pkg;

   localparam int WB_WIDTH      = 2;
   localparam int MA_WIDTH      = 5;
   localparam int RDSADDR_WIDTH = 5;

   // bit positions inside the EX/MA memory-control bundle
   localparam int MA_RD      = 0;
   localparam int MA_WR      = 1;
   localparam int MA_SIZE_LO = 2;
   localparam int MA_SIZE_HI = 3;
   localparam int MA_SIGNED  = 4;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } ma_state_t;

endpackage

// File: rtl/ma_load_align.sv
// rtl/ma_load_align.sv - selects the addressed byte/half lane of a read word and sign/zero-extends it
module ma_load_align
   import ma_stage_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic [WIDTH-1:0] rdata,
   input  logic [1:0]       offset,
   input  logic [1:0]       size,
   input  logic             sign_ext,
   output logic [WIDTH-1:0] data
);

   logic [WIDTH-1:0] lane;

   assign lane = rdata >> {offset, 3'b000};

   // narrow the shifted lane to the access size and extend it back to full width
   always_comb begin
      data = rdata;
      case (size)
         SIZE_BYTE: data = {{(WIDTH-8){sign_ext & lane[7]}}, lane[7:0]};
         SIZE_HALF: data = {{(WIDTH-16){sign_ext & lane[15]}}, lane[15:0]};
         default:   data = rdata;
      endcase
   end

endmodule

// File: rtl/ma_stage.sv
// rtl/ma_stage.sv - memory-access pipeline stage with req/ack data bus, ack timeout and MA/WB register (optional MA_SUBWORD_EN)
module ma_stage
   import ma_stage_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int TIMEOUT_BITS = 4
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WB_WIDTH-1:0]      i_EXMA_WB,
   input  logic [MA_WIDTH-1:0]      i_EXMA_MEM,
   input  logic [WIDTH-1:0]         i_EXMA_ALU_rslt,
   input  logic [WIDTH-1:0]         i_EXMA_Rs2_val,
   input  logic [WIDTH-1:0]         i_EXMA_PC,
   input  logic [RDSADDR_WIDTH-1:0] i_EXMA_Rds_addr,
   input  logic                     i_MAWB_flush,
   output logic                     o_MA_stall,
   output logic [WIDTH-1:0]         o_Data_From_MEM,
   output logic                     o_dmem_req,
   output logic                     o_dmem_we,
   output logic [WIDTH-1:0]         o_dmem_addr,
   output logic [WIDTH-1:0]         o_dmem_wdata,
   output logic [3:0]               o_dmem_be,
   input  logic                     i_dmem_ack,
   input  logic [WIDTH-1:0]         i_dmem_rdata,
   output logic                     o_bus_err,
   output logic [WB_WIDTH-1:0]      o_MAWB_WB,
   output logic [WIDTH-1:0]         o_MAWB_Rdata,
   output logic [WIDTH-1:0]         o_MAWB_ALU_rslt,
   output logic [RDSADDR_WIDTH-1:0] o_MAWB_Rds_addr,
   output logic [WIDTH-1:0]         o_MAWB_PC
);

   ma_state_t               state, state_next;
   logic [TIMEOUT_BITS-1:0] cnt;
   logic                    ma_wr, ma_rd, memop, timeout, req_c, bubble;
   logic [1:0]              addr_lo;
   logic [WIDTH-1:0]        load_data;

   // a write wins if both strobes are ever set together
   assign ma_wr   = i_EXMA_MEM[MA_WR];
   assign ma_rd   = i_EXMA_MEM[MA_RD] & ~ma_wr;
   assign memop   = ma_rd | ma_wr;
   assign addr_lo = i_EXMA_ALU_rslt[1:0];

   // an ack in the final wait cycle still completes the access
   assign timeout    = (state == ST_WAIT) & (&cnt) & ~i_dmem_ack;
   assign o_MA_stall = memop & ~i_dmem_ack & ~timeout;
   assign bubble     = i_MAWB_flush | o_MA_stall | timeout;

   assign o_Data_From_MEM = i_EXMA_ALU_rslt;
   assign o_dmem_addr     = {i_EXMA_ALU_rslt[WIDTH-1:2], 2'b00};
   assign o_dmem_we       = ma_wr;
   // reset kills the request immediately, even mid-access
   assign o_dmem_req      = req_c & reset;

`ifdef MA_SUBWORD_EN
   // lane-replicate store data and build byte enables; misaligned halves/words get no enables
   always_comb begin
      o_dmem_wdata = i_EXMA_Rs2_val;
      o_dmem_be    = 4'b0000;
      case (i_EXMA_MEM[MA_SIZE_HI:MA_SIZE_LO])
         SIZE_BYTE: begin
            o_dmem_wdata = {(WIDTH/8){i_EXMA_Rs2_val[7:0]}};
            o_dmem_be    = 4'b0001 << addr_lo;
         end
         SIZE_HALF: begin
            o_dmem_wdata = {(WIDTH/16){i_EXMA_Rs2_val[15:0]}};
            o_dmem_be    = addr_lo[0] ? 4'b0000 : (4'b0011 << {addr_lo[1], 1'b0});
         end
         default: begin
            o_dmem_be    = (addr_lo == 2'b00) ? 4'b1111 : 4'b0000;
         end
      endcase
   end

   ma_load_align #(.WIDTH(WIDTH)) u_load_align (
      .rdata    (i_dmem_rdata),
      .offset   (addr_lo),
      .size     (i_EXMA_MEM[MA_SIZE_HI:MA_SIZE_LO]),
      .sign_ext (i_EXMA_MEM[MA_SIGNED]),
      .data     (load_data)
   );
`else
   logic unused_cfg;

   assign o_dmem_wdata = i_EXMA_Rs2_val;
   assign o_dmem_be    = 4'b1111;
   assign load_data    = i_dmem_rdata;
   assign unused_cfg   = ^{i_EXMA_MEM[MA_SIZE_HI:MA_SIZE_LO], i_EXMA_MEM[MA_SIGNED]};
`endif

   // bus FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   // next-state and request: issue from IDLE, hold in WAIT until ack or timeout
   always_comb begin
      state_next = state;
      req_c      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (memop) begin
               req_c = 1'b1;
               if (!i_dmem_ack) state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            req_c = 1'b1;
            if (i_dmem_ack || timeout) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // wait counter: held at zero in IDLE so every WAIT entry starts from zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                 cnt <= '0;
      else if (state == ST_IDLE)  cnt <= '0;
      else                        cnt <= cnt + {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};
   end

   // one-cycle bus error pulse following a timeout
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) o_bus_err <= 1'b0;
      else        o_bus_err <= timeout;
   end

   // MA/WB register: bubble on flush, stall or timeout; load data only on a completing load
   always_ff @(posedge clk or negedge reset) begin
      if (!reset || bubble) begin
         o_MAWB_WB       <= '0;
         o_MAWB_Rdata    <= '0;
         o_MAWB_ALU_rslt <= '0;
         o_MAWB_Rds_addr <= '0;
         o_MAWB_PC       <= '0;
      end else begin
         o_MAWB_WB       <= i_EXMA_WB;
         o_MAWB_Rdata    <= (ma_rd & i_dmem_ack) ? load_data : '0;
         o_MAWB_ALU_rslt <= i_EXMA_ALU_rslt;
         o_MAWB_Rds_addr <= i_EXMA_Rds_addr;
         o_MAWB_PC       <= i_EXMA_PC;
      end
   end

endmodule

// File: tb/tb_ma_stage.sv
// tb/tb_ma_stage.sv - randomized self-checking bench for ma_stage against a cycle-level reference model
module tb_ma_stage;
   import ma_stage_pkg::*;

   localparam int W    = 32;
   localparam int TB   = 4;
   localparam int TO_K = (1 << TB);   // cycles after issue at which an unanswered access times out
`ifdef MA_SUBWORD_EN
   localparam bit SUBWORD = 1'b1;
`else
   localparam bit SUBWORD = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     reset = 1'b0;
   logic [WB_WIDTH-1:0]      exma_wb = '0;
   logic [MA_WIDTH-1:0]      exma_mem = '0;
   logic [W-1:0]             exma_alu = '0, exma_rs2 = '0, exma_pc = '0;
   logic [RDSADDR_WIDTH-1:0] exma_rds = '0;
   logic                     mawb_flush = 1'b0;
   logic                     ma_stall, dmem_req, dmem_we, bus_err, dmem_ack = 1'b0;
   logic [W-1:0]             data_from_mem, dmem_addr, dmem_wdata, dmem_rdata = '0;
   logic [3:0]               dmem_be;
   logic [WB_WIDTH-1:0]      mawb_wb;
   logic [W-1:0]             mawb_rdata, mawb_alu, mawb_pc;
   logic [RDSADDR_WIDTH-1:0] mawb_rds;

   int total = 0;
   int bad   = 0;

   ma_stage #(.WIDTH(W), .TIMEOUT_BITS(TB)) dut (
      .clk             (clk),
      .reset           (reset),
      .i_EXMA_WB       (exma_wb),
      .i_EXMA_MEM      (exma_mem),
      .i_EXMA_ALU_rslt (exma_alu),
      .i_EXMA_Rs2_val  (exma_rs2),
      .i_EXMA_PC       (exma_pc),
      .i_EXMA_Rds_addr (exma_rds),
      .i_MAWB_flush    (mawb_flush),
      .o_MA_stall      (ma_stall),
      .o_Data_From_MEM (data_from_mem),
      .o_dmem_req      (dmem_req),
      .o_dmem_we       (dmem_we),
      .o_dmem_addr     (dmem_addr),
      .o_dmem_wdata    (dmem_wdata),
      .o_dmem_be       (dmem_be),
      .i_dmem_ack      (dmem_ack),
      .i_dmem_rdata    (dmem_rdata),
      .o_bus_err       (bus_err),
      .o_MAWB_WB       (mawb_wb),
      .o_MAWB_Rdata    (mawb_rdata),
      .o_MAWB_ALU_rslt (mawb_alu),
      .o_MAWB_Rds_addr (mawb_rds),
      .o_MAWB_PC       (mawb_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                            input logic [1:0] sz, input logic sg);
      longint v;
      int     off;
      off = int'(addr[1:0]);
      if (!SUBWORD || sz > 2'd1) return rdata;
      if (sz == 2'd0) begin
         v = (longint'(rdata) >> (8 * off)) & 64'hFF;
         if (sg && v >= 128) v = v - 256;
      end else begin
         v = (longint'(rdata) >> (8 * off)) & 64'hFFFF;
         if (sg && v >= 32768) v = v - 65536;
      end
      return v[31:0];
   endfunction

   function automatic logic [3:0] ref_be(input logic [31:0] addr, input logic [1:0] sz);
      int off;
      off = int'(addr[1:0]);
      if (!SUBWORD) return 4'hF;
      if (sz == 2'd0) return 4'(1 << off);
      if (sz == 2'd1) return (off % 2 != 0) ? 4'h0 : 4'(3 << off);
      return (off == 0) ? 4'hF : 4'h0;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [1:0] sz);
      if (!SUBWORD || sz > 2'd1) return d;
      if (sz == 2'd0) return {24'h0, d[7:0]} * 32'h01010101;
      return {16'h0, d[15:0]} * 32'h00010001;
   endfunction

   task automatic check_mawb_zero(input string tag);
      check({tag, "_wb"},    64'(mawb_wb),    64'h0);
      check({tag, "_rdata"}, 64'(mawb_rdata), 64'h0);
      check({tag, "_alu"},   64'(mawb_alu),   64'h0);
      check({tag, "_rds"},   64'(mawb_rds),   64'h0);
      check({tag, "_pc"},    64'(mawb_pc),    64'h0);
   endtask

   // one EX/MA instruction held until it leaves the stage; lat = cycle of the ack (beyond TO_K: never)
   task automatic run_instr(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                            input int lat, input logic idle_ack, input int flush_pct);
      logic       memop, ld, ack, to, fl;
      logic [1:0] wbv;
      logic [4:0] rdsv;
      logic [31:0] pcv;
      memop = rd | wr;
      ld    = rd & ~wr;
      wbv   = 2'($urandom);
      rdsv  = 5'($urandom);
      pcv   = $urandom;
      exma_wb  = wbv;
      exma_mem = '0;
      exma_mem[MA_RD] = rd;
      exma_mem[MA_WR] = wr;
      exma_mem[MA_SIZE_HI:MA_SIZE_LO] = sz;
      exma_mem[MA_SIGNED] = sg;
      exma_alu = a;
      exma_rs2 = d;
      exma_pc  = pcv;
      exma_rds = rdsv;
      for (int k = 0; k <= TO_K; k++) begin
         ack = memop ? (k == lat) : idle_ack;
         to  = memop && !ack && (k == TO_K);
         fl  = ($urandom_range(0, 99) < flush_pct);
         dmem_ack   = ack;
         dmem_rdata = ack ? rdat : $urandom;
         mawb_flush = fl;
         @(negedge clk);
         check("req",   64'(dmem_req), 64'(memop));
         check("stall", 64'(ma_stall), 64'(memop && !ack && !to));
         check("fwd",   64'(data_from_mem), 64'(a));
         if (memop) begin
            check("addr",  64'(dmem_addr),  64'(a & 32'hFFFF_FFFC));
            check("we",    64'(dmem_we),    64'(wr));
            check("be",    64'(dmem_be),    64'(ref_be(a, sz)));
            if (wr) check("wdata", 64'(dmem_wdata), 64'(ref_wdata(d, sz)));
         end
         @(posedge clk);
         #1;
         check("bus_err", 64'(bus_err), 64'(to));
         if (fl || (memop && !ack)) begin
            check_mawb_zero("bubble");
         end else begin
            check("mawb_wb",    64'(mawb_wb),    64'(wbv));
            check("mawb_rdata", 64'(mawb_rdata), 64'((ld && ack) ? ref_load(rdat, a, sz, sg) : 32'h0));
            check("mawb_alu",   64'(mawb_alu),   64'(a));
            check("mawb_rds",   64'(mawb_rds),   64'(rdsv));
            check("mawb_pc",    64'(mawb_pc),    64'(pcv));
         end
         if (!memop || ack || to) break;
      end
      dmem_ack   = 1'b0;
      mawb_flush = 1'b0;
   endtask

   initial begin
      int lat;
      logic rd, wr;
      // reset state, with a load already presented: no request may escape
      exma_mem[MA_RD] = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req", 64'(dmem_req), 64'h0);
      check("rst_err", 64'(bus_err), 64'h0);
      check_mawb_zero("rst");
      exma_mem = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;

      // directed: zero-wait word load, 3-wait store, timeout, ack on the timeout cycle
      run_instr(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, 0);
      run_instr(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h204, 32'h12345678, 32'h0, 3, 1'b0, 0);
      run_instr(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h300, 32'h0, 32'h0, 1000, 1'b0, 0);
      run_instr(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h304, 32'h0, 32'hCAFEF00D, 1, 1'b0, 0);
      run_instr(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h308, 32'h0, 32'h0BADCAFE, TO_K, 1'b0, 0);
      // byte loads from lane 3, signed and unsigned
      run_instr(1'b1, 1'b0, SIZE_BYTE, 1'b1, 32'h103, 32'h0, 32'h80000000, 0, 1'b0, 0);
      run_instr(1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h103, 32'h0, 32'h80000000, 2, 1'b0, 0);
      // both strobes set: treated as a store
      run_instr(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h40, 32'hA5A5A5A5, 32'hFFFFFFFF, 0, 1'b0, 0);
      // stray ack with no memory op
      run_instr(1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h44, 32'h0, 32'h0, 0, 1'b1, 0);
      // flush during a wait: request stays up until the ack
      run_instr(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h48, 32'h0, 32'h11223344, 4, 1'b0, 100);

      // reset mid-access: request dies at once and MA/WB clears
      exma_mem = '0;
      exma_mem[MA_RD] = 1'b1;
      exma_alu = 32'h500;
      exma_wb  = 2'b11;
      dmem_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("midrst_req", 64'(dmem_req), 64'h0);
      check_mawb_zero("midrst");
      @(negedge clk);
      check("midrst_req_hold", 64'(dmem_req), 64'h0);
      exma_mem = '0;
      exma_alu = '0;
      exma_wb  = '0;
      exma_pc  = '0;
      exma_rds = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      check("late_ack_req",   64'(dmem_req), 64'h0);
      check("late_ack_stall", 64'(ma_stall), 64'h0);
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      check_mawb_zero("late_ack");
      check("late_ack_err", 64'(bus_err), 64'h0);
      run_instr(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h504, 32'h0, 32'h76543210, 2, 1'b0, 0);

      // random mix
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 2))
            0:       begin rd = 1'b1; wr = 1'b0; end
            1:       begin rd = 1'b0; wr = 1'b1; end
            default: begin rd = 1'b0; wr = 1'b0; end
         endcase
         case ($urandom_range(0, 9))
            0:       lat = 1000;
            1:       lat = TO_K;
            default: lat = $urandom_range(0, 4);
         endcase
         run_instr(rd, wr, 2'($urandom_range(0, 2)), 1'($urandom), $urandom, $urandom, $urandom,
                   lat, 1'($urandom), 10);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ma_stage.md
# ma_stage

Memory-access stage of the pipeline. It consumes the EX/MA pipeline register outputs and drives a req/ack data-memory bus for loads and stores. It stalls the front of the pipeline while an access is outstanding and loads the MA/WB pipeline register. It also supplies the MEM-stage forwarding value back to operand selection.

## Interface

Parameters:
- `WIDTH`, 32: data/address width.
- `TIMEOUT_BITS`, 4: width of the ack-timeout counter; timeout fires after 2^TIMEOUT_BITS−1 wait cycles.

Ports:
- `clk` in 1: clock; everything is rising-edge.
- `reset` in 1: reset, asynchronous, active-low.
- `i_EXMA_WB` in `WB_WIDTH`: WB control from EX/MA.
- `i_EXMA_MEM` in `MA_WIDTH`: MA control; fields `MA_RD`, `MA_WR`, `MA_SIZE[1:0]`, `MA_SIGNED`.
- `i_EXMA_ALU_rslt` in WIDTH: effective address or ALU result.
- `i_EXMA_Rs2_val` in WIDTH: store data.
- `i_EXMA_PC` in WIDTH: PC.
- `i_EXMA_Rds_addr` in `RDSADDR_WIDTH`: destination register.
- `i_MAWB_flush` in 1: flush request from the stall unit.
- `o_MA_stall` out 1: stall request to the stall unit; freezes IF..EXMA.
- `o_Data_From_MEM` out WIDTH: forwarding value, equal to `i_EXMA_ALU_rslt`.
- `o_dmem_req` out 1: request valid.
- `o_dmem_we` out 1: request is a write.
- `o_dmem_addr` out WIDTH: word-aligned address.
- `o_dmem_wdata` out WIDTH: write data, lane-aligned.
- `o_dmem_be` out 4: byte enables.
- `i_dmem_ack` in 1: access complete; `i_dmem_rdata` is valid in the same cycle.
- `i_dmem_rdata` in WIDTH: read data.
- `o_bus_err` out 1: one-cycle pulse on timeout.
- `o_MAWB_WB` out `WB_WIDTH`: registered WB control.
- `o_MAWB_Rdata` out WIDTH: registered, formatted load data.
- `o_MAWB_ALU_rslt` out WIDTH: registered ALU result.
- `o_MAWB_Rds_addr` out `RDSADDR_WIDTH`: registered destination register.
- `o_MAWB_PC` out WIDTH: registered PC.

## Operation

- `memop = MA_RD | MA_WR`. `MA_RD` and `MA_WR` are never both set; if both are set, `MA_WR` wins.
- FSM states are IDLE and WAIT.
- IDLE, no memop: no bus activity. The MA/WB register loads the EX/MA fields with `Rdata` = 0.
- IDLE, memop: `o_dmem_req` = 1 combinationally in the same cycle.
  - Ack in that cycle: complete and stay IDLE.
  - No ack: go to WAIT and clear the counter.
- WAIT: hold `o_dmem_req`=1. Address, data, be and we stay stable because EX/MA is frozen by the stall. Counter increments each cycle.
  - Ack: complete and go to IDLE.
  - Counter all-ones without ack: timeout. Pulse `o_bus_err`, drop `o_dmem_req`, write a bubble into MA/WB (WB control zeroed), go to IDLE.
- Completion:
  - Load: MA/WB captures the formatted `i_dmem_rdata`.
  - Store: MA/WB captures fields with `Rdata` = 0.
- `o_MA_stall` = memop & ~i_dmem_ack & ~timeout. It is combinational and deasserts in the completion cycle, so EX/MA advances on that same edge.
- While `o_MA_stall`=1, MA/WB loads a bubble with WB control zeroed.
- `i_MAWB_flush`: MA/WB loads a bubble next edge. A bus transaction already issued is never abandoned; flush has no effect on `o_dmem_req`.
- Address: `o_dmem_addr` = `{ALU_rslt[WIDTH-1:2], 2'b00}`.

## Timing

- Zero-wait memory (ack with req): a load completes in 1 cycle with no stall. Load data is visible at `o_MAWB_Rdata` one edge after the ack.
- N wait cycles produce N stall cycles.
- Reset values:
  - FSM = IDLE, counter = 0.
  - `o_bus_err` = 0.
  - MA/WB register all zero.
  - `o_dmem_req` = 0 for as long as reset is asserted, including when reset hits mid-access; the outstanding access is dropped.
- An ack arriving in IDLE without req is ignored.
- Ack and timeout in the same cycle: ack wins.

## Configuration

- `MA_SUBWORD_EN` defined: `MA_SIZE` is honoured (00 byte, 01 half, 10 word).
  - Store: data is replicated to lanes; be = 0001 << addr[1:0] for byte, 0011 << {addr[1],1'b0} for half.
  - Load: the addressed lane is selected, then sign-extended if `MA_SIGNED`, zero-extended otherwise.
  - A misaligned half (addr[0]=1) or word (addr[1:0]≠0) is issued with be = 0000 and completes as a normal access.
- Undefined: word-only. be = 1111, rdata passes through unmodified, `MA_SIZE` and `MA_SIGNED` are ignored.

## Structure

- `pipelinedefs.v` gains:
  - `MA_RD`, `MA_WR`, `MA_SIZE`, `MA_SIGNED` field macros.
  - `MAWB_WIDTH` and the `MAWB_*` slice macros.
  - FSM state encodings.
- The MA/WB register reuses the existing `pipereg`. Flush input = `i_MAWB_flush | o_MA_stall | timeout`; stall input tied 0.
- Lane select and extension go in one sub-module, `ma_load_align`, shared with any future cache fill path.

## Test plan

- Word load to 0x100, ack with req, rdata 0xDEADBEEF → no stall; `o_MAWB_Rdata`=0xDEADBEEF next edge; be=1111.
- Store to 0x204 with 0x12345678, ack after 3 cycles → `o_MA_stall` high exactly 3 cycles; addr/wdata stable throughout; MA/WB shows 3 bubbles then the store.
- Load with no ack, TIMEOUT_BITS=4 → `o_bus_err` pulses once after 15 wait cycles; req drops; MA/WB WB control=0; next instruction proceeds.
- `MA_SUBWORD_EN`: signed byte load from 0x103, rdata 0x80000000 → be=1000, Rdata=0xFFFFFF80; unsigned → 0x00000080.
- Reset asserted during WAIT → req=0 immediately; FSM IDLE; MA/WB zero. A later ack is ignored.
- `i_MAWB_flush` during WAIT → req held until ack; MA/WB receives a bubble.
